pc_sequencer: RTL and testbench

Fetch-side program-counter controller for the 32-bit MIPS core. It owns the architectural fetch PC, issues instruction-memory requests over a req/ack handshake, and applies exception, branch and jump redirects and pipeline stalls. It delivers (pc, instr) pairs to decode through a one-entry output register backed by a one-entry skid buffer. It replaces free-running PC+4 sequencing with flow-controlled, redirect-aware sequencing.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/pc_sequencer_if.sv | 24 ++
 rtl/fetch_skid.sv | 46 ++++
 rtl/pc_sequencer.sv | 177 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-side types and constants for the MIPS core front end.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] EXC_VECTOR   = 32'h8000_0180;
    localparam logic [XLEN-1:0] INSTR_BYTES  = 32'h0000_0004;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        IDLE  = 2'd2,
        DRAIN = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        RS_NONE = 2'd0,
        RS_EXC  = 2'd1,
        RS_BR   = 2'd2,
        RS_JUMP = 2'd3
    } redir_src_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

    // Clear the byte-offset bits of a fetch address.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory request/ack bus between the sequencer and imem.
interface pc_sequencer_if;
    import mips_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_skid.sv
// One-entry (pc, instr) holding buffer that absorbs a fetch returned while decode stalls.
module fetch_skid
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  fetch_pkt_t load_pkt,
    input  logic       unload,
    input  logic       flush,
    output logic       valid,
    output fetch_pkt_t pkt
);

    logic       valid_q, valid_d;
    fetch_pkt_t pkt_q, pkt_d;

    // Flush beats load; a load in the same cycle as unload replaces the entry.
    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pkt_d   = load_pkt;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

    assign valid = valid_q;
    assign pkt   = pkt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC controller: flow-controlled, redirect-aware imem sequencing into a decode output register.
module pc_sequencer
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    pc_sequencer_if.master  imem,
    input  logic            stall,
    input  logic            exc,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] instr,
    output logic            pc_valid
);

    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;

    redir_src_e      redir_src;
    logic [XLEN-1:0] redir_tgt;
    logic            redirect;
    logic            ack_ok;
    logic            advance;
    logic            word_ok;

    logic            sk_valid;
    fetch_pkt_t      sk_pkt;
    fetch_pkt_t      new_pkt;
    logic            sk_load, sk_unload, sk_flush;

    fetch_skid u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (sk_load),
        .load_pkt (new_pkt),
        .unload   (sk_unload),
        .flush    (sk_flush),
        .valid    (sk_valid),
        .pkt      (sk_pkt)
    );

    assign new_pkt = '{pc: addr_q, instr: imem.imem_rdata};
    assign ack_ok  = imem.imem_ack && req_q;
    assign advance = !valid_q || !stall;

    // Redirect source priority (exception, branch, jump) and aligned target.
    always_comb begin
        redir_src = RS_NONE;
        if (exc) begin
            redir_src = RS_EXC;
        end else if (br_taken) begin
            redir_src = RS_BR;
        end else if (jump) begin
            redir_src = RS_JUMP;
        end
        case (redir_src)
            RS_EXC:  redir_tgt = EXC_VECTOR;
            RS_BR:   redir_tgt = word_align(br_target);
            RS_JUMP: redir_tgt = word_align(jump_target);
            default: redir_tgt = addr_q;
        endcase
        redirect = (redir_src != RS_NONE);
    end

    // Next-state, fetch address and output-register update.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tgt_d     = tgt_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        sk_load   = 1'b0;
        sk_unload = 1'b0;
        sk_flush  = 1'b0;
        word_ok   = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = FETCH;
                if (redirect) addr_d = redir_tgt;
            end
            FETCH: begin
                if (redirect) begin
                    if (ack_ok) begin
                        addr_d = redir_tgt;
                    end else begin
                        tgt_d   = redir_tgt;
                        state_d = DRAIN;
                    end
                end else if (ack_ok) begin
                    word_ok = 1'b1;
                    addr_d  = addr_q + INSTR_BYTES;
                    // The skid stays occupied if decode is stalled or it already holds a word.
                    state_d = (!advance || sk_valid) ? IDLE : FETCH;
                end
            end
            IDLE: begin
                if (redirect) begin
                    addr_d  = redir_tgt;
                    state_d = FETCH;
                end else if (advance || !sk_valid) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) tgt_d = redir_tgt;
                if (ack_ok) begin
                    addr_d  = redirect ? redir_tgt : tgt_q;
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase

        if (redirect) begin
            valid_d  = 1'b0;
            sk_flush = 1'b1;
        end else if (advance) begin
            if (sk_valid) begin
                pc_d      = sk_pkt.pc;
                instr_d   = sk_pkt.instr;
                valid_d   = 1'b1;
                sk_unload = 1'b1;
                sk_load   = word_ok;
            end else if (word_ok) begin
                pc_d    = new_pkt.pc;
                instr_d = new_pkt.instr;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            sk_load = word_ok;
        end

        req_d = (state_d == FETCH) || (state_d == DRAIN);
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            addr_q  <= RESET_VECTOR;
            tgt_q   <= RESET_VECTOR;
            req_q   <= 1'b0;
            pc_q    <= RESET_VECTOR;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tgt_q   <= tgt_d;
            req_q   <= req_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + INSTR_BYTES;
    assign instr          = instr_q;
    assign pc_valid       = valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a per-cycle vector table plus hand sequences for reset and redirect corners.
module tb_pc_sequencer;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, ack_i, exc, br_taken, jump;
    logic [31:0] br_target, jump_target;
    logic [31:0] pc, pc_plus4, instr;
    logic        pc_valid;

    int checks = 0;
    int errors = 0;

    pc_sequencer_if bus ();

    // Memory image: every word is a recognisable function of its address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus.imem_ack   = ack_i;
    assign bus.imem_rdata = mem_fn(bus.imem_addr);

    pc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (bus),
        .stall       (stall),
        .exc         (exc),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jump        (jump),
        .jump_target (jump_target),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr       (instr),
        .pc_valid    (pc_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        ack;
        logic        exc;
        logic        br;
        logic [31:0] bt;
        logic        jump;
        logic [31:0] jt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    localparam int unsigned NVEC = 27;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic s, input logic a, input logic e, input logic b,
                                input logic [31:0] bt, input logic j, input logic [31:0] jt,
                                input logic rq, input logic [31:0] ad, input logic v,
                                input logic [31:0] p);
        vec_t r;
        r.stall = s;  r.ack = a;  r.exc = e;  r.br = b;  r.bt = bt;  r.jump = j;  r.jt = jt;
        r.e_req = rq; r.e_addr = ad; r.e_valid = v; r.e_pc = p;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Compare all observable outputs; instr is only meaningful while pc_valid.
    task automatic obs(input string tag, input logic rq, input logic [31:0] ad,
                       input logic v, input logic [31:0] p);
        logic [31:0] p4;
        p4 = p + 32'd4;
        chk({tag, ".req"},   32'(bus.imem_req), 32'(rq));
        chk({tag, ".addr"},  bus.imem_addr, ad);
        chk({tag, ".valid"}, 32'(pc_valid), 32'(v));
        chk({tag, ".pc"},    pc, p);
        chk({tag, ".pc4"},   pc_plus4, p4);
        if (v) chk({tag, ".instr"}, instr, mem_fn(p));
    endtask

    task automatic drive(input logic s, input logic a, input logic e, input logic b,
                         input logic [31:0] bt, input logic j, input logic [31:0] jt);
        stall = s; ack_i = a; exc = e; br_taken = b; br_target = bt; jump = j; jump_target = jt;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //           stall ack exc br  bt            jmp jt            | req addr          valid pc
        tbl[0]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,          0, 32'h0,         0, 32'h0);
        tbl[1]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h0,         0, 32'h0);
        tbl[2]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h4,         1, 32'h0);
        tbl[3]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h8,         1, 32'h4);
        tbl[4]  = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,          1, 32'hC,         1, 32'h8);
        tbl[5]  = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,          0, 32'h10,        1, 32'h8);
        tbl[6]  = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,          0, 32'h10,        1, 32'h8);
        tbl[7]  = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,          0, 32'h10,        1, 32'h8);
        tbl[8]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,          0, 32'h10,        1, 32'h8);
        tbl[9]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h10,        1, 32'hC);
        tbl[10] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,          1, 32'h14,        1, 32'h10);
        tbl[11] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,          1, 32'h14,        0, 32'h10);
        tbl[12] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,          1, 32'h14,        0, 32'h10);
        tbl[13] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h14,        0, 32'h10);
        tbl[14] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,          1, 32'h18,        1, 32'h14);
        tbl[15] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h18,        0, 32'h14);
        tbl[16] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h1C,        1, 32'h18);
        tbl[17] = mk(0, 0, 0, 1, 32'h0000_0102, 0, 32'h0,          1, 32'h20,        1, 32'h1C);
        tbl[18] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,          1, 32'h20,        0, 32'h1C);
        tbl[19] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h20,        0, 32'h1C);
        tbl[20] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,          1, 32'h100,       0, 32'h1C);
        tbl[21] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h100,       0, 32'h1C);
        tbl[22] = mk(0, 1, 1, 0, 32'h0,         1, 32'h40,         1, 32'h104,       1, 32'h100);
        tbl[23] = mk(0, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFFF,  1, 32'h8000_0180, 0, 32'h100);
        tbl[24] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h8000_0180, 0, 32'h100);
        tbl[25] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h100);
        tbl[26] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,          1, 32'h0,         1, 32'hFFFF_FFFC);

        // Reset values, with a stray ack that must be ignored.
        reset = 1'b0;
        drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
        @(negedge clk);
        tick();
        obs("rst", 0, RESET_VECTOR, 0, RESET_VECTOR);
        chk("rst.instr", instr, 32'h0);

        // Release reset and run the cycle table.
        reset = 1'b1;
        for (int i = 0; i < int'(NVEC); i++) begin
            obs($sformatf("r%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_pc);
            drive(tbl[i].stall, tbl[i].ack, tbl[i].exc, tbl[i].br, tbl[i].bt, tbl[i].jump, tbl[i].jt);
            tick();
        end

        // Wrapped fetch: redirect with no ack enters DRAIN holding address 0.
        obs("wrap", 1, 32'h0, 0, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 32'h0, 1, 32'h300);
        tick();
        obs("drain", 1, 32'h0, 0, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);

        // Reset mid-DRAIN takes effect before the next clock edge.
        #2 reset = 1'b0;
        #1;
        chk("arst.req",   32'(bus.imem_req), 32'h0);
        chk("arst.valid", 32'(pc_valid), 32'h0);
        chk("arst.addr",  bus.imem_addr, RESET_VECTOR);
        @(negedge clk);

        // Redirect from IDLE flushes the skid word.
        reset = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
        tick();
        obs("c0", 1, 32'h0, 0, 32'h0);
        drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
        tick();
        obs("c1", 1, 32'h4, 1, 32'h0);
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        tick();
        obs("c2", 0, 32'h8, 1, 32'h0);
        drive(1, 0, 0, 1, 32'h53, 0, 32'h0);
        tick();
        obs("c3", 1, 32'h50, 0, 32'h0);
        drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
        tick();
        obs("c4", 1, 32'h54, 1, 32'h50);
        drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
        tick();
        obs("c5", 1, 32'h58, 1, 32'h54);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
